// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 core scheduler:
//   - sched_state_t : scheduler state encoding
//   - MSG_BEATS     : 10-bit beats per message (640 bits)
//   - HASH_BEATS    : 10-bit digest beats (256 digest bits + 4 pad bits)
// -----------------------------------------------------------------------------
package sha256_pkg;

  localparam int MSG_BEATS  = 64;
  localparam int HASH_BEATS = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_WAIT,
    ST_DRAIN,
    ST_CLEAN
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: picks the first active request at or after
// i_ptr, wrapping around modulo N_REQ.
// Ports:
//   i_req     in  N_REQ  request vector
//   i_ptr     in  IW     search start position (0..N_REQ-1)
//   o_gnt     out N_REQ  one-hot grant, all zero when no request
//   o_gnt_id  out IW     index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_gnt_id
);

  // w_pos[k] is the requester index visited k steps after the pointer;
  // w_rot is the request vector rotated so that bit 0 is the pointer position.
  logic [IW-1:0]    w_pos [N_REQ];
  logic [N_REQ-1:0] w_rot;
  logic             w_found;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [IW:0] w_sum;
      // One extra bit holds ptr+gi (at most 2*N_REQ-2) before the wrap.
      assign w_sum      = {1'b0, i_ptr} + (IW+1)'(gi);
      assign w_pos[gi]  = (w_sum >= (IW+1)'(N_REQ)) ? IW'(w_sum - (IW+1)'(N_REQ))
                                                    : w_sum[IW-1:0];
      assign w_rot[gi]  = i_req[w_pos[gi]];
    end
  endgenerate

  always_comb begin
    w_found  = 1'b0;
    o_gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found  = 1'b1;
        o_gnt_id = w_pos[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign o_gnt[gi] = w_found && (o_gnt_id == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/sha256_sched.sv
// -----------------------------------------------------------------------------
// sha256_sched
// Shares one 10-bit streaming SHA-256 core between N_REQ requesters. One job
// (MSG_BEATS accepted beats) is granted at a time, round-robin. The scheduler
// pulses core_start, streams the granted requester's beats into the core,
// forwards HASH_BEATS digest beats tagged with the owner, and then holds the
// core in reset for one cycle because the core never clears its own counters
// and keeps core_valid_out high after the final digest beat.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_data      per-requester message beats (N_REQ x 10 bits)
//   req_ready               per-requester accept, one-hot or zero
//   res_valid/res_data      registered digest beat stream (no backpressure)
//   res_id                  owner of the current result
//   res_last                final digest beat, or with the error pulse
//   res_err                 one-cycle pulse when the digest wait times out
//   busy                    scheduler not idle
//   core_rst_n              core synchronous reset (low during rst_n or CLEAN)
//   core_start              core start pulse
//   core_valid_in/core_message_in   beats towards the core
//   core_hash_out/core_valid_out    digest beats from the core
// -----------------------------------------------------------------------------
module sha256_sched #(
  parameter int N_REQ      = 4,
  parameter int MSG_BEATS  = sha256_pkg::MSG_BEATS,
  parameter int HASH_BEATS = sha256_pkg::HASH_BEATS,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*10-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  output logic [9:0]               res_data,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic                     res_last,
  output logic                     res_err,
  output logic                     busy,
  output logic                     core_rst_n,
  output logic                     core_start,
  output logic                     core_valid_in,
  output logic [9:0]               core_message_in,
  input  logic [9:0]               core_hash_out,
  input  logic                     core_valid_out
);
  import sha256_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [6:0]    LP_BEAT_MAX  = 7'(MSG_BEATS);
  localparam logic [6:0]    LP_BEAT_LAST = 7'(MSG_BEATS - 1);
  localparam logic [4:0]    LP_HASH_LAST = 5'(HASH_BEATS - 1);
  localparam logic [TW-1:0] LP_TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LP_ID_MAX    = IW'(N_REQ - 1);

  sched_state_t  r_state;
  logic [IW-1:0] r_gnt_id;
  logic [IW-1:0] r_rr_ptr;
  logic [6:0]    r_beat_cnt;
  logic [4:0]    r_hash_cnt;
  logic [TW-1:0] r_timer;
  logic          r_res_valid;
  logic [9:0]    r_res_data;
  logic [IW-1:0] r_res_id;
  logic          r_res_last;
  logic          r_res_err;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_gnt_id;
  logic             w_any;
  logic             w_load_open;
  logic             w_accept;
  logic [9:0]       w_req_data [N_REQ];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign w_any       = |w_gnt;
  assign w_load_open = (r_state == ST_LOAD) && (r_beat_cnt < LP_BEAT_MAX);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_req_data[gi] = req_data[gi*10 +: 10];
      assign req_ready[gi]  = w_load_open && (r_gnt_id == IW'(gi));
    end
  endgenerate

  assign w_accept        = req_valid[r_gnt_id] & req_ready[r_gnt_id];
  assign core_valid_in   = w_accept;
  assign core_message_in = (r_state == ST_LOAD) ? w_req_data[r_gnt_id] : 10'd0;
  assign core_start      = (r_state == ST_START);
  // The core has no idle return; CLEAN is its only way back to a clean start.
  assign core_rst_n      = rst_n & (r_state != ST_CLEAN);
  assign busy            = (r_state != ST_IDLE);

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_last  = r_res_last;
  assign res_err   = r_res_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_id    <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_hash_cnt  <= '0;
      r_timer     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_last  <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt_id <= w_gnt_id;
            r_rr_ptr <= (w_gnt_id == LP_ID_MAX) ? '0 : w_gnt_id + 1'b1;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          r_beat_cnt <= '0;
          r_hash_cnt <= '0;
          r_state    <= ST_LOAD;
        end
        ST_LOAD: begin
          // w_accept implies r_beat_cnt < MSG_BEATS, so the count saturates.
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (r_beat_cnt == LP_BEAT_LAST) begin
              r_timer <= '0;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (core_valid_out) begin
            r_res_valid <= 1'b1;
            r_res_data  <= core_hash_out;
            r_res_id    <= r_gnt_id;
            r_hash_cnt  <= 5'd1;
            r_state     <= ST_DRAIN;
          end else if (r_timer == LP_TMO_LAST) begin
            // Abort decided on the edge where the timer reaches TIMEOUT.
            r_res_err  <= 1'b1;
            r_res_last <= 1'b1;
            r_res_id   <= r_gnt_id;
            r_state    <= ST_CLEAN;
          end
        end
        ST_DRAIN: begin
          if (core_valid_out) begin
            r_res_valid <= 1'b1;
            r_res_data  <= core_hash_out;
            r_res_id    <= r_gnt_id;
            r_hash_cnt  <= r_hash_cnt + 1'b1;
            if (r_hash_cnt == LP_HASH_LAST) begin
              r_res_last <= 1'b1;
              r_state    <= ST_CLEAN;
            end
          end
        end
        ST_CLEAN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_sched.sv
// -----------------------------------------------------------------------------
// tb_sha256_sched
// Directed bench for sha256_sched with a behavioural core stand-in. The stand-in
// folds the 64 received beats into an order-sensitive 32-bit value and emits a
// digest derived from it, holding core_valid_out high afterwards like the real
// core. Expected digests are derived from the beats the bench itself handed
// over, so any dropped, duplicated, reordered or misrouted beat shows up.
// -----------------------------------------------------------------------------
module tb_sha256_sched;

  localparam int N   = 4;
  localparam int TMO = 255;
  localparam int LAT = 133;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*10-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              res_valid;
  logic [9:0]        res_data;
  logic [1:0]        res_id;
  logic              res_last;
  logic              res_err;
  logic              busy;
  logic              core_rst_n;
  logic              core_start;
  logic              core_valid_in;
  logic [9:0]        core_message_in;
  logic [9:0]        core_hash_out;
  logic              core_valid_out;

  always #5 clk = ~clk;

  sha256_sched #(
    .N_REQ      (N),
    .MSG_BEATS  (64),
    .HASH_BEATS (26),
    .TIMEOUT    (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .res_id          (res_id),
    .res_last        (res_last),
    .res_err         (res_err),
    .busy            (busy),
    .core_rst_n      (core_rst_n),
    .core_start      (core_start),
    .core_valid_in   (core_valid_in),
    .core_message_in (core_message_in),
    .core_hash_out   (core_hash_out),
    .core_valid_out  (core_valid_out)
  );

  function automatic logic [9:0] dig(input logic [31:0] h, input int k);
    logic [31:0] t;
    t = (h ^ (h >> 13)) + 32'(k) * 32'd37 + 32'd5;
    return t[9:0];
  endfunction

  // ---------------- core stand-in ----------------
  int          st_mode = 0;      // 0 normal, 1 silent, 2 valid for 40 cycles
  logic        st_on = 1'b0;
  int          st_k = 0;
  int          st_dly = 0;
  logic [31:0] st_h = '0;
  logic [31:0] st_h_done = '0;
  int          st_cnt = 0;
  int          st_vin_cnt = 0;
  int          st_t = 0;
  int          st_start_t = 0;
  int          st_first_t = 0;

  assign core_valid_out = st_on;
  assign core_hash_out  = dig(st_h_done, st_k);

  always @(posedge clk) begin
    st_t <= st_t + 1;
    if (!core_rst_n) begin
      st_on  <= 1'b0;
      st_k   <= 0;
      st_dly <= 0;
      st_h   <= '0;
      st_cnt <= 0;
    end else begin
      if (core_start) begin
        st_cnt     <= 0;
        st_h       <= '0;
        st_vin_cnt <= 0;
        st_start_t <= st_t;
      end
      if (core_valid_in) begin
        st_vin_cnt <= st_vin_cnt + 1;
        if (st_vin_cnt == 0) st_first_t <= st_t;
        if (st_cnt < 64) begin
          st_h   <= st_h * 32'd31 + 32'(core_message_in);
          st_cnt <= st_cnt + 1;
          if (st_cnt == 63) begin
            st_h_done <= st_h * 32'd31 + 32'(core_message_in);
            st_dly    <= 1;
          end
        end
      end
      if (st_dly > 0) begin
        if (st_dly == LAT) begin
          st_dly <= 0;
          if (st_mode != 1) st_on <= 1'b1;
        end else begin
          st_dly <= st_dly + 1;
        end
      end
      if (st_on) begin
        if (st_mode == 2) begin
          if (st_k == 39) st_on <= 1'b0;
          else st_k <= st_k + 1;
        end else if (st_k < 25) begin
          st_k <= st_k + 1;
        end
      end
    end
  end

  // ---------------- bench state ----------------
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          rem [N];
  int          duty [N];
  logic [9:0]  nxt [N];
  logic [9:0]  stepv [N];
  int          acc_cnt [N];
  logic [31:0] job_h [N];
  logic [31:0] done_h [N];
  int          cur_beats = 0;
  int          cvi_cnt = 0;
  int          last_cvi_cyc = 0;
  int          err_cyc = 0;
  logic        rstn_at_last = 1'b1;
  int          onehot_bad = 0;
  int          job_id_q [$];
  int          job_beats_q [$];
  int          job_err_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int qget(input int q [$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_req();
    for (int r = 0; r < N; r++) begin
      rem[r]     = 0;
      duty[r]    = 100;
      acc_cnt[r] = 0;
      job_h[r]   = '0;
    end
  endtask

  // One clock: account for the handshakes of this edge, then drive and monitor.
  task automatic step();
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    if ($countones(req_ready) > 1) onehot_bad++;
    if (core_valid_in) begin
      cvi_cnt++;
      if (cvi_cnt == 64) last_cvi_cyc = cyc;
    end
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        job_h[r] = job_h[r] * 32'd31 + 32'(nxt[r]);
        acc_cnt[r]++;
        if (acc_cnt[r] == 64) begin
          done_h[r]  = job_h[r];
          job_h[r]   = '0;
          acc_cnt[r] = 0;
        end
        nxt[r] = nxt[r] + stepv[r];
        rem[r]--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < N; r++) begin
      if (rem[r] > 0) begin
        if (!req_valid[r] || acc[r]) req_valid[r] = ($urandom_range(0, 99) < duty[r]);
      end else begin
        req_valid[r] = 1'b0;
      end
      req_data[r*10 +: 10] = nxt[r];
    end
    if (res_valid) begin
      check_val($sformatf("digest id%0d b%0d", res_id, cur_beats), 32'(res_data),
                32'(dig(done_h[res_id], cur_beats)));
      cur_beats++;
    end
    if (res_last) begin
      job_id_q.push_back(int'(res_id));
      job_beats_q.push_back(cur_beats);
      job_err_q.push_back(int'(res_err));
      rstn_at_last = core_rst_n;
      if (res_err) err_cyc = cyc;
      $display("job done id=%0d beats=%0d err=%0d cyc=%0d", res_id, cur_beats, res_err, cyc);
      cur_beats = 0;
    end
  endtask

  task automatic run_jobs(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (job_id_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check_val(tag, job_id_q.size(), n);
  endtask

  task automatic new_test();
    job_id_q.delete();
    job_beats_q.delete();
    job_err_q.delete();
    cur_beats  = 0;
    cvi_cnt    = 0;
    onehot_bad = 0;
  endtask

  initial begin
    clear_req();
    for (int r = 0; r < N; r++) begin
      nxt[r]    = '0;
      stepv[r]  = '0;
      done_h[r] = '0;
    end

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) step();
    check_val("rst req_ready", 32'(req_ready), 0);
    check_val("rst res_valid", 32'(res_valid), 0);
    check_val("rst res_data", 32'(res_data), 0);
    check_val("rst res_id", 32'(res_id), 0);
    check_val("rst res_last", 32'(res_last), 0);
    check_val("rst res_err", 32'(res_err), 0);
    check_val("rst busy", 32'(busy), 0);
    check_val("rst core_start", 32'(core_start), 0);
    check_val("rst core_valid_in", 32'(core_valid_in), 0);
    check_val("rst core_message_in", 32'(core_message_in), 0);
    check_val("rst core_rst_n", 32'(core_rst_n), 0);
    rst_n = 1'b1;
    step();
    check_val("idle core_rst_n", 32'(core_rst_n), 1);
    check_val("idle busy", 32'(busy), 0);

    // ---- T1: requester 0, 64 zero beats ----
    new_test();
    rem[0] = 64;
    run_jobs(1, 600, "t1 jobs");
    check_val("t1 id", qget(job_id_q, 0), 0);
    check_val("t1 beats", qget(job_beats_q, 0), 26);
    check_val("t1 err", qget(job_err_q, 0), 0);
    check_val("t1 core_rst_n at last", 32'(rstn_at_last), 0);
    check_val("t1 core beats", st_vin_cnt, 64);
    step();
    check_val("t1 core_rst_n after", 32'(core_rst_n), 1);
    check_val("t1 busy after", 32'(busy), 0);

    // ---- T2: requesters 0,1,3 valid at reset release ----
    new_test();
    rst_n = 1'b0;
    step();
    step();
    clear_req();
    rem[0] = 128; nxt[0] = 10'h100; stepv[0] = 10'd3;
    rem[1] = 64;  nxt[1] = 10'h055; stepv[1] = 10'd11;
    rem[3] = 64;  nxt[3] = 10'h3f0; stepv[3] = 10'd1;
    step();
    rst_n = 1'b1;
    run_jobs(4, 2000, "t2 jobs");
    check_val("t2 order0", qget(job_id_q, 0), 0);
    check_val("t2 order1", qget(job_id_q, 1), 1);
    check_val("t2 order2", qget(job_id_q, 2), 3);
    check_val("t2 order3", qget(job_id_q, 3), 0);
    check_val("t2 beats3", qget(job_beats_q, 3), 26);
    check_val("t2 onehot", onehot_bad, 0);

    // ---- T3: requester 2 with 50% valid duty ----
    new_test();
    rem[2] = 64; duty[2] = 50; nxt[2] = 10'h2aa; stepv[2] = 10'd5;
    run_jobs(1, 900, "t3 jobs");
    check_val("t3 id", qget(job_id_q, 0), 2);
    check_val("t3 beats", qget(job_beats_q, 0), 26);
    check_val("t3 core beats", st_vin_cnt, 64);
    check_val("t3 core data order", st_h_done, done_h[2]);
    check_val("t3 start gap", 32'(st_first_t - st_start_t >= 1), 1);
    check_val("t3 onehot", onehot_bad, 0);

    // ---- T4: silent core, timeout abort, then a normal job ----
    new_test();
    st_mode = 1;
    rem[1] = 64; nxt[1] = 10'h0f0; stepv[1] = 10'd7;
    run_jobs(1, 800, "t4 jobs");
    check_val("t4 err", qget(job_err_q, 0), 1);
    check_val("t4 id", qget(job_id_q, 0), 1);
    check_val("t4 beats", qget(job_beats_q, 0), 0);
    // Last beat accepted on the edge closing cycle last_cvi_cyc; the abort is
    // registered TMO edges later, so it is visible TMO+1 cycles on.
    check_val("t4 err delay", err_cyc - last_cvi_cyc, TMO + 1);
    check_val("t4 core_rst_n at err", 32'(rstn_at_last), 0);
    step();
    check_val("t4 busy after", 32'(busy), 0);
    st_mode = 0;
    rem[1] = 64;
    run_jobs(2, 600, "t4 recover jobs");
    check_val("t4 recover err", qget(job_err_q, 1), 0);
    check_val("t4 recover beats", qget(job_beats_q, 1), 26);

    // ---- T5: rst_n pulse at load beat 30 ----
    new_test();
    rem[0] = 64; nxt[0] = 10'h011; stepv[0] = 10'd9;
    begin
      int c;
      c = 0;
      while (cvi_cnt < 30 && c < 200) begin
        step();
        c++;
      end
    end
    check_val("t5 reached beat 30", cvi_cnt, 30);
    rst_n = 1'b0;
    step();
    check_val("t5 busy in reset", 32'(busy), 0);
    check_val("t5 core_rst_n in reset", 32'(core_rst_n), 0);
    check_val("t5 res_valid in reset", 32'(res_valid), 0);
    rst_n = 1'b1;
    acc_cnt[0] = 0;
    job_h[0]   = '0;
    rem[0]     = 64;
    run_jobs(1, 600, "t5 jobs");
    check_val("t5 id", qget(job_id_q, 0), 0);
    check_val("t5 beats", qget(job_beats_q, 0), 26);
    check_val("t5 err", qget(job_err_q, 0), 0);

    // ---- T6: core valid held 40 cycles ----
    new_test();
    st_mode = 2;
    rem[3] = 64; nxt[3] = 10'h1c3; stepv[3] = 10'd13;
    run_jobs(1, 600, "t6 jobs");
    check_val("t6 beats", qget(job_beats_q, 0), 26);
    repeat (30) step();
    check_val("t6 no extra jobs", job_id_q.size(), 1);
    check_val("t6 no extra beats", cur_beats, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
